// File: rtl/control_flow_unit.sv
// control_flow_unit
// Turns structured control instructions into push/pop traffic for the control
// stack and resolves fetch redirects. Branches and returns unwind one frame per
// cycle; overflow and underflow land in a sticky TRAP state left only by reset.
module control_flow_unit #(
   parameter int ADDR_W  = 8,
   parameter int SP_W    = 4,
   parameter int FRAME_W = 2 + 1 + SP_W + ADDR_W,
   parameter int DEPTH   = 16,
   parameter int DEPTH_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               op_valid,
   output logic               op_ready,
   input  logic [2:0]         op_kind,
   input  logic               op_cond,
   input  logic [DEPTH_W-1:0] op_depth,
   input  logic [ADDR_W-1:0]  op_pc,
   input  logic [ADDR_W-1:0]  op_target,
   input  logic               op_retnum,
   input  logic [SP_W-1:0]    op_sp,
   output logic               cs_push,
   output logic               cs_pop,
   output logic [FRAME_W-1:0] cs_push_data,
   input  logic [FRAME_W-1:0] cs_top_data,
   input  logic               cs_empty,
   output logic               jump_valid,
   output logic [ADDR_W-1:0]  jump_addr,
   output logic [SP_W-1:0]    jump_sp_tag,
   output logic               jump_retnum,
   output logic               done,
   output logic               trap
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_UNWIND = 2'd1,
      S_RET    = 2'd2,
      S_TRAP   = 2'd3
   } state_t;

   localparam logic [2:0] OP_BLOCK  = 3'd0;
   localparam logic [2:0] OP_LOOP   = 3'd1;
   localparam logic [2:0] OP_IF     = 3'd2;
   localparam logic [2:0] OP_CALL   = 3'd3;
   localparam logic [2:0] OP_END    = 3'd4;
   localparam logic [2:0] OP_BR     = 3'd5;
   localparam logic [2:0] OP_BR_IF  = 3'd6;
   localparam logic [2:0] OP_RETURN = 3'd7;

   localparam logic [1:0] T_BLOCK = 2'b00;
   localparam logic [1:0] T_CALL  = 2'b01;
   localparam logic [1:0] T_IF    = 2'b10;
   localparam logic [1:0] T_LOOP  = 2'b11;

   localparam int               CNT_W    = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DEPTH_W-1:0]   k_q, k_d;
   logic                 jump_valid_q, jump_valid_d;
   logic [ADDR_W-1:0]    jump_addr_q, jump_addr_d;
   logic [SP_W-1:0]      jump_sp_q, jump_sp_d;
   logic                 jump_ret_q, jump_ret_d;
   logic                 done_q, done_d;
   logic                 trap_q, trap_d;

   logic                 push_req;
   logic                 pop_req;
   logic                 push_want;
   logic                 push_jump;
   logic [FRAME_W-1:0]   frame_cand;
   logic [FRAME_W-1:0]   push_frame;

   logic [1:0]           top_type;
   logic                 top_ret;
   logic [SP_W-1:0]      top_sp;
   logic [ADDR_W-1:0]    top_addr;

   assign top_type = cs_top_data[FRAME_W-1 -: 2];
   assign top_ret  = cs_top_data[ADDR_W+SP_W];
   assign top_sp   = cs_top_data[ADDR_W +: SP_W];
   assign top_addr = cs_top_data[ADDR_W-1:0];

   function automatic logic [FRAME_W-1:0] make_frame(
      input logic [1:0]        t,
      input logic              r,
      input logic [SP_W-1:0]   s,
      input logic [ADDR_W-1:0] a
   );
      return {t, r, s, a};
   endfunction

   // Next-state, stack traffic and redirect resolution for the sequencer
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      k_d          = k_q;
      jump_valid_d = 1'b0;
      jump_addr_d  = jump_addr_q;
      jump_sp_d    = jump_sp_q;
      jump_ret_d   = jump_ret_q;
      done_d       = 1'b0;
      trap_d       = trap_q;
      push_req     = 1'b0;
      pop_req      = 1'b0;
      push_want    = 1'b0;
      push_jump    = 1'b0;
      frame_cand   = '0;
      push_frame   = '0;

      case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               case (op_kind)
                  OP_BLOCK: begin
                     push_want  = 1'b1;
                     frame_cand = make_frame(T_BLOCK, op_retnum, op_sp, op_target);
                  end
                  OP_LOOP: begin
                     push_want  = 1'b1;
                     frame_cand = make_frame(T_LOOP, op_retnum, op_sp, op_pc);
                  end
                  OP_IF: begin
                     push_want  = 1'b1;
                     push_jump  = ~op_cond;
                     frame_cand = make_frame(T_IF, op_retnum, op_sp, op_target);
                  end
                  OP_CALL: begin
                     push_want  = 1'b1;
                     push_jump  = 1'b1;
                     frame_cand = make_frame(T_CALL, op_retnum, op_sp, op_pc + ADDR_W'(1));
                  end
                  OP_END: begin
                     if (cs_empty) begin
                        done_d = 1'b1;
                     end else begin
                        pop_req = 1'b1;
                        if (top_type == T_CALL) begin
                           jump_valid_d = 1'b1;
                           jump_addr_d  = top_addr;
                           jump_sp_d    = top_sp;
                           jump_ret_d   = top_ret;
                        end
                     end
                  end
                  OP_BR: begin
                     k_d     = op_depth;
                     state_d = S_UNWIND;
                  end
                  OP_BR_IF: begin
                     if (op_cond) begin
                        k_d     = op_depth;
                        state_d = S_UNWIND;
                     end
                  end
                  OP_RETURN: begin
                     state_d = S_RET;
                  end
                  default: begin
                  end
               endcase

               if (push_want) begin
                  if (cnt_q == CNT_FULL) begin
                     trap_d  = 1'b1;
                     state_d = S_TRAP;
                  end else begin
                     push_req   = 1'b1;
                     push_frame = frame_cand;
                     if (push_jump) begin
                        jump_valid_d = 1'b1;
                        jump_addr_d  = op_target;
                        jump_sp_d    = op_sp;
                        jump_ret_d   = op_retnum;
                     end
                  end
               end
            end
         end

         S_UNWIND: begin
            if (cs_empty) begin
               trap_d  = 1'b1;
               state_d = S_TRAP;
            end else if (k_q != '0) begin
               pop_req = 1'b1;
               k_d     = k_q - DEPTH_W'(1);
            end else begin
               pop_req      = (top_type != T_LOOP);
               jump_valid_d = 1'b1;
               jump_addr_d  = top_addr;
               jump_sp_d    = top_sp;
               jump_ret_d   = top_ret;
               state_d      = S_IDLE;
            end
         end

         S_RET: begin
            if (cs_empty) begin
               trap_d  = 1'b1;
               state_d = S_TRAP;
            end else begin
               pop_req = 1'b1;
               if (top_type == T_CALL) begin
                  jump_valid_d = 1'b1;
                  jump_addr_d  = top_addr;
                  jump_sp_d    = top_sp;
                  jump_ret_d   = top_ret;
                  state_d      = S_IDLE;
               end
            end
         end

         S_TRAP: begin
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (push_req && !pop_req) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (pop_req && !push_req && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // State, occupancy, unwind counter and registered redirect/status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         k_q          <= '0;
         jump_valid_q <= 1'b0;
         jump_addr_q  <= '0;
         jump_sp_q    <= '0;
         jump_ret_q   <= 1'b0;
         done_q       <= 1'b0;
         trap_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         k_q          <= k_d;
         jump_valid_q <= jump_valid_d;
         jump_addr_q  <= jump_addr_d;
         jump_sp_q    <= jump_sp_d;
         jump_ret_q   <= jump_ret_d;
         done_q       <= done_d;
         trap_q       <= trap_d;
      end
   end

   assign op_ready     = (state_q == S_IDLE);
   assign cs_push      = push_req;
   assign cs_pop       = pop_req;
   assign cs_push_data = push_frame;
   assign jump_valid   = jump_valid_q;
   assign jump_addr    = jump_addr_q;
   assign jump_sp_tag  = jump_sp_q;
   assign jump_retnum  = jump_ret_q;
   assign done         = done_q;
   assign trap         = trap_q;

endmodule

// File: doc/control_flow_unit.md
# control_flow_unit

Sequencer that translates structured control instructions (block, loop, if, call, end, br, br_if, return) into push/pop traffic for the control stack. It also resolves the resulting branch target, operand-stack tag and return count for the fetch stage. It sits between the instruction decoder (upstream, valid/ready) and the control stack (downstream, push/pop/top interface). Multi-level branches are unwound one frame per cycle.

## Interface
- ADDR_W, 8, instruction address width
- SP_W, 4, operand-stack pointer tag width
- FRAME_W, 15, frame width = 2 + 1 + SP_W + ADDR_W
- DEPTH, 16, control stack capacity in frames
- DEPTH_W, 4, width of op_depth and of the unwind counter

Frame layout is {type[1:0], retnum, sp_tag[SP_W-1:0], addr[ADDR_W-1:0]}. Type codes: block=00, call=01, if=10, loop=11.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- op_valid  in  1  decoder presents an instruction
- op_ready  out  1  instruction accepted when op_valid && op_ready
- op_kind  in  3  0 BLOCK, 1 LOOP, 2 IF, 3 CALL, 4 END, 5 BR, 6 BR_IF, 7 RETURN
- op_cond  in  1  condition for IF / BR_IF
- op_depth  in  DEPTH_W  label depth for BR / BR_IF
- op_pc  in  ADDR_W  address of this instruction
- op_target  in  ADDR_W  callee address (CALL) or matching end/else address (BLOCK, IF)
- op_retnum  in  1  frame return count
- op_sp  in  SP_W  current operand-stack pointer tag
- cs_push  out  1  push to control stack
- cs_pop  out  1  pop from control stack
- cs_push_data  out  FRAME_W  frame to push
- cs_top_data  in  FRAME_W  current top frame, valid when cs_empty=0
- cs_empty  in  1  control stack empty
- jump_valid  out  1  one-cycle pulse: redirect fetch
- jump_addr  out  ADDR_W  redirect address
- jump_sp_tag  out  SP_W  operand-stack tag to restore
- jump_retnum  out  1  values to keep across the jump
- done  out  1  one-cycle pulse: END executed on an empty stack (program exit)
- trap  out  1  sticky error flag

## Operation
- FSM states: IDLE, UNWIND, RET, TRAP.
- op_ready = 1 only in IDLE. cs_push and cs_pop are combinational from the accepting op or the current state.
- Internal occupancy counter `cnt` (0..DEPTH): +1 on push, −1 on pop, unchanged on simultaneous push and pop.

Opcode behaviour (accepted in IDLE):
- **BLOCK:** push {00, op_retnum, op_sp, op_target}.
- **LOOP:** push {11, op_retnum, op_sp, op_pc}.
- **IF:** push {10, op_retnum, op_sp, op_target}. If op_cond=0, also jump to op_target.
- **CALL:** push {01, op_retnum, op_sp, op_pc+1} (mod 2^ADDR_W). Jump to op_target with jump_sp_tag=op_sp.
- **END:**
  - Stack empty: done pulse.
  - Otherwise pop. If the popped type is 01, jump to its addr, sp_tag and retnum.
- **BR:** load `k = op_depth`, go to UNWIND.
- **BR_IF:** if op_cond=0, no-op; otherwise behaves as BR.
- **RETURN:** go to RET.

UNWIND, one frame per cycle:
- k>0: pop, k−1.
- k=0, top type 11: jump to top addr with no pop; the loop label is kept.
- k=0, other type: pop and jump to top addr.
- Return to IDLE after the jump.

RET, one frame per cycle:
- Pop the top frame.
- When the popped frame is type 01, jump to it and return to IDLE.

Trap conditions (enter TRAP, raise trap):
- Push with cnt=DEPTH; the push is suppressed.
- Pop or inspect with cs_empty=1 in UNWIND or RET.

In TRAP, op_ready=0, no push or pop, and the state is left only by reset.

Jump fields are registered and hold their last value between pulses.

## Timing
- Reset values: op_ready=1 (state IDLE), cs_push=0, cs_pop=0, cs_push_data=0, jump_valid=0, jump_addr=0, jump_sp_tag=0, jump_retnum=0, done=0, trap=0, cnt=0.
- BLOCK / LOOP / IF(true): 1 cycle, no jump.
- IF(false), CALL, END-of-call: jump_valid asserted the cycle after acceptance.
- BR depth d: pops occur on cycles 1..d after acceptance. The target is resolved on cycle d+1, and jump_valid follows on cycle d+2. op_ready returns on cycle d+2.
- RETURN with n frames above the call frame: pops on cycles 1..n+1, jump_valid on cycle n+2.
- done and jump_valid are never asserted together. jump_valid and trap are never asserted together.
- Reset mid-UNWIND or mid-RET: state returns to IDLE and all outputs take their reset values. The control stack is reset by the same rst_n.

## Test plan
- Push BLOCK(target 0x20), LOOP(pc 0x10), then BR depth 0 → no pop, jump_addr=0x10 two cycles after accept, cnt stays 2.
- BLOCK(0x40), BLOCK(0x30), IF(cond=1, target 0x38), then BR depth 2 → 2 pops, third frame popped, jump_addr=0x40, cnt=0, op_ready back at cycle 4.
- CALL at pc 0xFF, target 0x05, op_sp=3 → jump to 0x05; then BLOCK, BLOCK, RETURN → 3 pops, jump_addr=0x00 (wrap), jump_sp_tag=3.
- IF cond=0, target 0x22 → push plus jump_addr=0x22 next cycle; BR_IF cond=0 → no push/pop/jump, op_ready stays 1.
- DEPTH+1 consecutive BLOCKs → 16 pushes, 17th suppressed, trap=1, op_ready=0 until rst_n low.
- END on empty stack → done pulse for 1 cycle, no pop. BR depth 1 with one frame → trap. Assert rst_n low mid-UNWIND → all outputs at reset values next cycle.
